seq_mult7_ctrl: RTL and testbench
=================================

SEQ_MULT7_CTRL -- requirements
Module: seq_mult7_ctrl

Interface
REQ-001 Parameter: N, default 7, operand width; only 7 is supported, matching the 7-bit adder datapath.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only when the block is not busy.
REQ-005 Port: a  input  7  multiplicand, unsigned, captured on the accepted start.
REQ-006 Port: b  input  7  multiplier, unsigned, captured on the accepted start.
REQ-007 Port: busy  output  1  high while in RUN.
REQ-008 Port: done  output  1  single-cycle pulse when product becomes valid.
REQ-009 Port: product  output  14  unsigned a*b; held until the next accepted start.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, RUN and DONE.
REQ-011 Start acceptance SHALL follow these rules:
- start=1 in IDLE or DONE is accepted.
- An accepted start captures a into mcand, b into mq and clears acc_hi[6:0].
- It loads cnt=0 and moves to RUN on the next edge.
REQ-012 Start during RUN SHALL be ignored, with no effect on state, operands or count.
REQ-013 Each RUN cycle SHALL compute sum[7:0] = acc_hi + (mq[0] ? mcand : 0) through the 7-bit ripple adder with carry-in 0.
REQ-014 Each RUN cycle SHALL then shift {sum[7:0], mq[6:0]} right by one into {acc_hi, mq}, and increment cnt.
REQ-015 RUN SHALL last exactly 7 cycles; on the edge where cnt=6 the FSM SHALL go to DONE.
REQ-016 In DONE, product SHALL equal {acc_hi, mq}, done=1 for exactly that one cycle, and the next state SHALL be IDLE, or RUN if start=1.
REQ-017 Latency SHALL be 8 cycles from the accepted-start edge to done=1 (1 load edge + 7 RUN edges), with a throughput of one multiply per 8 cycles using back-to-back start in DONE.
REQ-018 The product register SHALL update only on entry to DONE; it SHALL NOT show intermediate values.
REQ-019 All arithmetic SHALL be unsigned; the carry into bit 7 of sum SHALL never be lost (max 127*127=16129 fits in 14 bits).
REQ-020 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE); both are decoded from registered state.

Reset
REQ-021 reset=1 SHALL asynchronously force:
- state=IDLE, cnt=0, mcand=0, mq=0, acc_hi=0;
- product=0, busy=0, done=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and product SHALL read 0.
REQ-023 After reset deassertion, the first start SHALL be accepted on the first rising edge with reset low.

Configuration
REQ-024 Macro SEQ_MULT7_EARLY_EXIT_EN, when defined, SHALL cause an accepted start with a==0 or b==0 to go directly to DONE on the next edge, with product=0, done=1 and latency 1 cycle.
REQ-025 When SEQ_MULT7_EARLY_EXIT_EN is undefined, zero operands SHALL take the full 8-cycle path, with product=0.

Structure
REQ-026 A shared package SHALL hold:
- the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the constants OPW=7, PRODW=14 and the final-count value 6.
REQ-027 The adder SHALL be the sole sub-module: the team's existing 7-bit ripple-carry fulladder chain (seven_fulladder), instantiated once.
REQ-028 The FSM, counter and shift registers SHALL be written in this module, with no other sub-modules.

Verification
REQ-029 Basic multiply: start with a=7'd13, b=7'd11 -> busy for 7 cycles, done pulse on cycle 8, product=14'd143.
REQ-030 Maximum operands: a=127, b=127 -> product=16129 (14'h3F01), with no overflow.
REQ-031 Back-to-back: start held high during DONE of (5*6) with a=9, b=9 -> done with 30, then RUN resumes immediately and the next done follows 8 cycles later with 81.
REQ-032 Start during RUN: pulse start with a=1, b=1 at RUN cycle 3 of a 3*4 job -> ignored, and product=12.
REQ-033 Reset mid-RUN: assert reset at RUN cycle 4 -> busy=0 and product=0 immediately, with no done pulse; a subsequent 2*3 job gives 6.
REQ-034 Zero operand: a=0, b=100 -> with SEQ_MULT7_EARLY_EXIT_EN, done 1 cycle after start; without it, done after 8 cycles; product=0 in both cases.

Source files
------------

// File: rtl/seq_mult7_ctrl_pkg.sv
// Shared constants for the 7x7 shift-add multiplier: state encoding and widths.
package seq_mult7_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int OPW   = 7;
    localparam int PRODW = 14;
    localparam logic [2:0] CNT_LAST = 3'd6;

endpackage

// File: rtl/seq_mult7_ctrl_seven_fulladder.sv
// 7-bit ripple-carry adder built as a chain of full-adder cells.
module seven_fulladder (
    input  logic [6:0] a_i,
    input  logic [6:0] b_i,
    input  logic       cin_i,
    output logic [6:0] sum_o,
    output logic       cout_o
);

    logic [7:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < 7; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[7];

endmodule

// File: rtl/seq_mult7_ctrl.sv
// Sequential 7x7 unsigned shift-add multiplier, 8 cycles per product.
// Optional SEQ_MULT7_EARLY_EXIT_EN: zero operand finishes one edge after start.
module seq_mult7_ctrl
    import seq_mult7_ctrl_pkg::*;
#(
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [OPW-1:0]    mcand_q, mcand_d;
    logic [OPW-1:0]    mq_q, mq_d;
    logic [OPW-1:0]    acc_hi_q, acc_hi_d;
    logic [PRODW-1:0]  product_q, product_d;

    logic [OPW-1:0]    addend;
    logic [OPW-1:0]    sum_lo;
    logic              sum_co;
    logic [OPW:0]      sum;

    assign addend = mq_q[0] ? mcand_q : '0;

    seven_fulladder u_add (
        .a_i    (acc_hi_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum_lo),
        .cout_o (sum_co)
    );

    // carry-out is kept as bit 7 so 127*127 never overflows
    assign sum = {sum_co, sum_lo};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mq_d      = mq_q;
        acc_hi_d  = acc_hi_q;
        product_d = product_q;
        unique case (state_q)
            RUN: begin
                acc_hi_d = sum[OPW:1];
                mq_d     = {sum[0], mq_q[OPW-1:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    product_d = {sum, mq_q[OPW-1:1]};
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    mcand_d  = a;
                    mq_d     = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef SEQ_MULT7_EARLY_EXIT_EN
                    if (a == '0 || b == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mq_q      <= '0;
            acc_hi_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mq_q      <= mq_d;
            acc_hi_q  <= acc_hi_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult7_ctrl.sv
// Directed bench for seq_mult7_ctrl with an expected-product scoreboard queue.
module tb_seq_mult7_ctrl;

`ifdef SEQ_MULT7_EARLY_EXIT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 8;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  a, b;
    logic        busy, done;
    logic [13:0] product;

    int          errors = 0;
    int          checks = 0;
    logic [13:0] exp_q[$];
    logic [13:0] prev_prod;

    always #5 clk = ~clk;

    seq_mult7_ctrl #(.N(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start for a single edge and record the expected product.
    task automatic launch(input logic [6:0] av, input logic [6:0] bv);
        prev_prod = product;
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(14'(av * bv));
        tick();
        start = 1'b0;
    endtask

    // 'cyc' edges have already passed since the accepting edge.
    task automatic wait_done(input string tag, input int cyc, input int lat, input bit chk_busy);
        int n;
        logic [13:0] expv;
        n = cyc;
        while (!done && n < 20) begin
            if (chk_busy) chk({tag, "_busy"}, busy, 1);
            chk({tag, "_hold"}, product, prev_prod);
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_lat"}, n, lat);
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            chk({tag, "_prod"}, product, expv);
        end else begin
            chk({tag, "_sb_empty"}, 1, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_prod", product, 0);
        tick();
        reset = 1'b0;

        // basic 13*11, start on the first edge after reset release
        launch(7'd13, 7'd11);
        wait_done("basic", 1, 8, 1'b1);
        tick();
        chk("basic_pulse", done, 0);
        chk("basic_idle_busy", busy, 0);
        chk("basic_held", product, 143);

        launch(7'd127, 7'd127);
        wait_done("max", 1, 8, 1'b1);
        chk("max_const", product, 16129);
        tick();

        // back-to-back: start held through DONE
        launch(7'd5, 7'd6);
        wait_done("b2b1", 1, 8, 1'b1);
        prev_prod = product;
        a = 7'd9;
        b = 7'd9;
        start = 1'b1;
        exp_q.push_back(14'd81);
        tick();
        start = 1'b0;
        chk("b2b_resume", busy, 1);
        wait_done("b2b2", 1, 8, 1'b1);
        tick();

        // start during RUN is ignored
        launch(7'd3, 7'd4);
        tick();
        tick();
        a = 7'd1;
        b = 7'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", busy, 1);
        wait_done("ign", 4, 8, 1'b1);
        tick();

        // reset mid-RUN
        launch(7'd10, 7'd10);
        void'(exp_q.pop_back());
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_prod", product, 0);
        chk("mrst_done", done, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("mrst_nodone", done, 0);
        end
        launch(7'd2, 7'd3);
        wait_done("after_rst", 1, 8, 1'b1);
        tick();

        // zero operands
        launch(7'd0, 7'd100);
        wait_done("zero_a", 1, ZLAT, ZLAT != 1);
        tick();
        launch(7'd50, 7'd0);
        wait_done("zero_b", 1, ZLAT, ZLAT != 1);
        tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
